// File: rtl/lut_mult_pipe.sv
// lut_mult_pipe: 3-stage N_CH-lane multiply by a table coefficient with round-half-up; define LUT_MULT_SAT_EN to saturate instead of wrap
module lut_mult_pipe #(
    parameter int IN_W    = 32,
    parameter int CONST_W = 18,
    parameter int FRAC    = 15,
    parameter int N_CH    = 4,
    parameter int DEPTH   = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_CH*IN_W-1:0]     in_data,
    input  logic [$clog2(DEPTH)-1:0] in_idx,
    input  logic                     coef_we,
    input  logic [$clog2(DEPTH)-1:0] coef_addr,
    input  logic [CONST_W-1:0]       coef_wdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_CH*IN_W-1:0]     out_data,
    output logic [N_CH-1:0]          out_sat
);
    localparam int PW = IN_W + CONST_W;
    localparam int RW = PW + 1;
    localparam logic [CONST_W-1:0] ONE = CONST_W'(1) << FRAC;
    localparam logic signed [RW-1:0] HALF = RW'(1) << (FRAC - 1);

    logic [CONST_W-1:0] tbl [DEPTH];
    logic v1, v2, v3, adv;
    logic [N_CH*IN_W-1:0] a1;
    logic signed [CONST_W-1:0] c1;
    logic signed [PW-1:0] p2 [N_CH];
    logic [N_CH*IN_W-1:0] res;
    logic [N_CH-1:0] sat;
    logic signed [RW-1:0] rnd;
`ifdef LUT_MULT_SAT_EN
    logic signed [RW-1:0] sh;
`endif

    assign adv       = out_ready | ~v3;
    assign in_ready  = adv;
    assign out_valid = v3;

    // coefficient table: unity after reset, writes land regardless of stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) tbl[i] <= ONE;
        end else if (coef_we) begin
            tbl[coef_addr] <= coef_wdata;
        end
    end

    // round half up, shift out the fraction, then wrap or clamp to IN_W
    always_comb begin
        res = '0;
        sat = '0;
        rnd = '0;
`ifdef LUT_MULT_SAT_EN
        sh  = '0;
`endif
        for (int i = 0; i < N_CH; i++) begin
            rnd = $signed({p2[i][PW-1], p2[i]}) + HALF;
`ifdef LUT_MULT_SAT_EN
            sh = rnd >>> FRAC;
            sat[i] = sh[RW-1:IN_W-1] != {(RW-IN_W+1){sh[RW-1]}};
            res[i*IN_W +: IN_W] = sat[i] ? {sh[RW-1], {(IN_W-1){~sh[RW-1]}}} : sh[IN_W-1:0];
`else
            res[i*IN_W +: IN_W] = IN_W'(rnd >>> FRAC);
`endif
        end
    end

    // pipeline stages: all advance together when the output is free or empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            v3       <= 1'b0;
            a1       <= '0;
            c1       <= '0;
            out_data <= '0;
            out_sat  <= '0;
            for (int i = 0; i < N_CH; i++) p2[i] <= '0;
        end else if (adv) begin
            v1 <= in_valid;
            a1 <= in_data;
            c1 <= tbl[in_idx];
            v2 <= v1;
            for (int i = 0; i < N_CH; i++) p2[i] <= PW'($signed(a1[i*IN_W +: IN_W])) * PW'(c1);
            v3 <= v2;
            if (v2) begin
                out_data <= res;
                out_sat  <= sat;
            end
        end
    end
endmodule

// File: tb/tb_lut_mult_pipe.sv
// tb_lut_mult_pipe: directed vectors, corner sequences and random traffic against a scoreboard model
module tb_lut_mult_pipe;
    localparam int IN_W = 32, CONST_W = 18, FRAC = 15, N_CH = 4, DEPTH = 64, AW = 6;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    typedef struct {
        logic [N_CH*IN_W-1:0] d;
        logic [N_CH-1:0]      s;
    } beat_t;

    typedef struct {
        logic [AW-1:0]        addr;
        logic [CONST_W-1:0]   coef;
        logic [N_CH*IN_W-1:0] a;
        logic [N_CH*IN_W-1:0] exp_d;
        logic [N_CH-1:0]      exp_s;
    } vec_t;

    logic clk, rst, in_valid, in_ready, coef_we, out_valid, out_ready;
    logic [N_CH*IN_W-1:0] in_data, out_data;
    logic [AW-1:0] in_idx, coef_addr;
    logic [CONST_W-1:0] coef_wdata;
    logic [N_CH-1:0] out_sat;

    int checks = 0, errors = 0, n_out = 0;
    beat_t sb[$];
    logic [CONST_W-1:0] tbl_m [DEPTH];
    logic stalled = 1'b0;
    logic [N_CH*IN_W-1:0] held_d;
    logic [N_CH-1:0] held_s;

    lut_mult_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_idx(in_idx), .coef_we(coef_we),
        .coef_addr(coef_addr), .coef_wdata(coef_wdata), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] pack4(input int l0, input int l1, input int l2, input int l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic beat_t model(input logic [N_CH*IN_W-1:0] d, input logic [CONST_W-1:0] c);
        beat_t e;
        longint p, r;
        e.d = '0;
        e.s = '0;
        for (int l = 0; l < N_CH; l++) begin
            p = longint'($signed(d[l*IN_W +: IN_W])) * longint'($signed(c));
            r = (p + (longint'(1) << (FRAC - 1))) >>> FRAC;
`ifdef LUT_MULT_SAT_EN
            if (r > MAXV) begin
                r = MAXV;
                e.s[l] = 1'b1;
            end else if (r < MINV) begin
                r = MINV;
                e.s[l] = 1'b1;
            end
`endif
            e.d[l*IN_W +: IN_W] = r[IN_W-1:0];
        end
        return e;
    endfunction

    // scoreboard: everything seen at the negedge happens at the next rising edge
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            sb.delete();
            stalled = 1'b0;
            for (int i = 0; i < DEPTH; i++) tbl_m[i] = CONST_W'(1) << FRAC;
        end else begin
            if (stalled && out_valid) begin
                check("stall_data_stable", out_data, held_d);
                check("stall_sat_stable", out_sat, held_s);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %0h expected none", out_data);
                end else begin
                    e = sb.pop_front();
                    check("sb_data", out_data, e.d);
                    check("sb_sat", out_sat, e.s);
                end
                n_out++;
            end
            if (in_valid && in_ready) sb.push_back(model(in_data, tbl_m[in_idx]));
            if (coef_we) tbl_m[coef_addr] = coef_wdata;
            stalled = out_valid && !out_ready;
            held_d = out_data;
            held_s = out_sat;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input string name);
        for (int k = 0; k < 12 && !out_valid; k++) tick();
        check(name, out_valid, 1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid = 1'b0;
        coef_we = 1'b0;
        for (int k = 0; k < 100 && (sb.size() != 0 || out_valid); k++) tick();
        check("drain_empty", sb.size(), 0);
    endtask

    function automatic logic [127:0] bp_beat(input int i);
        return pack4(i * 10, i * 10 + 1, -i, 1000 + i);
    endfunction

    initial begin
        vec_t vecs[4];
        int acc, base, seen;
        vecs[0] = '{5, 18'h04000, pack4(3, -3, 1, -1), pack4(2, -1, 1, 0), 4'b0000};
`ifdef LUT_MULT_SAT_EN
        vecs[1] = '{1, 18'h10000, pack4(32'h7FFFFFFF, 5, -5, 32'h80000000),
                    pack4(32'h7FFFFFFF, 10, -10, 32'h80000000), 4'b1001};
`else
        vecs[1] = '{1, 18'h10000, pack4(32'h7FFFFFFF, 5, -5, 32'h80000000),
                    pack4(32'hFFFFFFFE, 10, -10, 0), 4'b0000};
`endif
        vecs[2] = '{2, 18'h38000, pack4(100, -7, 0, 12345), pack4(-100, 7, 0, -12345), 4'b0000};
        vecs[3] = '{3, 18'h00001, pack4(16384, 16383, -16384, -16385), pack4(1, 0, 0, -1), 4'b0000};

        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_idx = '0;
        coef_we = 1'b0;
        coef_addr = '0;
        coef_wdata = '0;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sat", out_sat, 0);
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", in_ready, 1);

        in_valid = 1'b1;
        in_data = pack4(1000, 0, 0, 0);
        in_idx = 0;
        tick();
        in_valid = 1'b0;
        check("unity_lat1", out_valid, 0);
        tick();
        check("unity_lat2", out_valid, 0);
        tick();
        check("unity_lat3_valid", out_valid, 1);
        check("unity_lane0", out_data[31:0], 1000);
        tick();

        for (int v = 0; v < 4; v++) begin
            coef_we = 1'b1;
            coef_addr = vecs[v].addr;
            coef_wdata = vecs[v].coef;
            tick();
            coef_we = 1'b0;
            in_valid = 1'b1;
            in_data = vecs[v].a;
            in_idx = vecs[v].addr;
            tick();
            in_valid = 1'b0;
            wait_out("vec_valid");
            check("vec_data", out_data, vecs[v].exp_d);
            check("vec_sat", out_sat, vecs[v].exp_s);
            tick();
        end

        coef_we = 1'b1;
        coef_addr = 7;
        coef_wdata = 18'h08000;
        tick();
        coef_wdata = 18'h10000;
        in_valid = 1'b1;
        in_idx = 7;
        in_data = pack4(4, 0, 0, 0);
        tick();
        coef_we = 1'b0;
        tick();
        in_valid = 1'b0;
        wait_out("coll_valid_old");
        check("coll_old_coef", out_data[31:0], 4);
        tick();
        check("coll_valid_new", out_valid, 1);
        check("coll_new_coef", out_data[31:0], 8);
        drain();

        base = n_out;
        acc = 0;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_idx = 0;
        in_data = bp_beat(0);
        #1;
        for (int c = 0; c < 6; c++) begin
            if (in_ready) acc++;
            tick();
            in_data = bp_beat(acc);
        end
        check("bp_accepted_while_stalled", acc, 3);
        check("bp_in_ready_low", in_ready, 0);
        out_ready = 1'b1;
        #1;
        for (int k = 0; k < 20 && acc < 5; k++) begin
            if (in_ready) acc++;
            tick();
            in_data = bp_beat(acc);
        end
        in_valid = 1'b0;
        drain();
        check("bp_beats_out", n_out - base, 5);

        coef_we = 1'b1;
        coef_addr = 4;
        coef_wdata = 18'h0C000;
        tick();
        coef_we = 1'b0;
        in_valid = 1'b1;
        in_idx = 4;
        in_data = pack4(50, 60, 70, 80);
        tick();
        tick();
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        tick();
        tick();
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (out_valid) seen++;
        end
        check("midrst_no_stale", seen, 0);
        in_valid = 1'b1;
        in_data = pack4(77, -77, 0, 1);
        tick();
        in_valid = 1'b0;
        wait_out("midrst_unity_valid");
        check("midrst_unity", out_data, pack4(77, -77, 0, 1));
        drain();

        for (int c = 0; c < 400; c++) begin
            in_valid = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            for (int l = 0; l < N_CH; l++)
                in_data[l*IN_W +: IN_W] = ($urandom % 8 == 0) ? (($urandom % 2) ? 32'h7FFFFFFF : 32'h80000000) : $urandom;
            in_idx = AW'($urandom_range(0, DEPTH - 1));
            coef_we = ($urandom % 5) == 0;
            coef_addr = AW'($urandom_range(0, DEPTH - 1));
            coef_wdata = CONST_W'($urandom);
            tick();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lut_mult_pipe.md
LUT_MULT_PIPE -- requirements
Module: lut_mult_pipe

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- IN_W, 32, sample width; signed two's complement.
- CONST_W, 18, coefficient width; signed; FRAC fractional bits.
- FRAC, 15, fractional bits of the coefficient.
- N_CH, 4, parallel lanes sharing one coefficient per beat.
- DEPTH, 64, coefficient table entries; power of two.
- Legal range: CONST_W >= FRAC+2 and FRAC >= 1.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning. Clock and reset come first.
- clk, in, 1, single clock; all logic on the rising edge.
- rst, in, 1, asynchronous, active-high reset.
- in_valid, in, 1, input beat valid.
- in_ready, out, 1, input beat accepted when high together with in_valid.
- in_data, in, N_CH*IN_W, lane samples; lane 0 in the LSBs.
- in_idx, in, log2(DEPTH), coefficient table index for the beat.
- coef_we, in, 1, coefficient write enable.
- coef_addr, in, log2(DEPTH), coefficient write address.
- coef_wdata, in, CONST_W, coefficient write value.
- out_valid, out, 1, result beat valid.
- out_ready, in, 1, downstream accepts the beat.
- out_data, out, N_CH*IN_W, lane results.
- out_sat, out, N_CH, per-lane saturation flag.

Function
REQ-003 The datapath SHALL be a 3-stage pipeline:
- S1 registers the samples and the table read.
- S2 registers the signed product of width IN_W+CONST_W.
- S3 registers the rounded, shifted result.
REQ-004 Global advance SHALL be: adv = out_ready OR NOT out_valid.
- in_ready SHALL equal adv.
- When adv is low, every stage SHALL hold its contents.
REQ-005 Latency SHALL be 3 cycles from acceptance to out_valid under continuous adv.
- Throughput SHALL be 1 beat per cycle.
REQ-006 A valid bit per stage SHALL track occupancy.
- Bubbles SHALL propagate as invalid beats and never appear on out_valid.
REQ-007 Per lane, result = (a*coef + 2^(FRAC-1)) >>> FRAC, an arithmetic shift.
- Rounding is half toward +infinity.
REQ-008 Without saturation, the result SHALL be truncated to the low IN_W bits (wrap).
- out_sat SHALL be 0.
REQ-009 Coefficient table writes SHALL take effect at the clock edge.
- A same-cycle S1 read of the same address SHALL return the old value (read-before-write).
- Writes SHALL be accepted regardless of adv.
REQ-010 out_data and out_sat SHALL stay stable while out_valid=1 and out_ready=0.
REQ-011 When the pipeline is full and out_ready=0, in_ready SHALL be 0 and no beat SHALL be lost or duplicated.

Reset
REQ-012 On rst=1, asynchronously:
- all stage valid bits SHALL clear, so out_valid=0;
- out_data SHALL be 0;
- out_sat SHALL be 0;
- every table entry SHALL be 2^FRAC (unity).
REQ-013 in_ready SHALL read 1 during and after reset.
REQ-014 Reset asserted mid-operation SHALL discard all in-flight beats.
- The first beat after release SHALL see unity coefficients unless rewritten.

Configuration
REQ-015 Macro LUT_MULT_SAT_EN SHALL control saturation.
- Defined: each lane result is clamped to [-2^(IN_W-1), 2^(IN_W-1)-1], and the matching out_sat bit is 1 when clamping occurred.
- Undefined: wrap behaviour per REQ-008 applies, with out_sat tied to 0.
- Pipeline latency SHALL be identical in both builds.

Verification
REQ-016 Unity: defaults, a=1000, idx=0 -> out=1000 on lane 0, exactly 3 cycles after acceptance.
REQ-017 Rounding: write coef[5]=0x04000 (0.5), lanes a={3,-3,1,-1} -> out={2,-1,1,0}.
REQ-018 Overflow: coef[1]=0x10000 (2.0), a=0x7FFFFFFF.
- With LUT_MULT_SAT_EN: out=0x7FFFFFFF, out_sat[0]=1.
- Without it: out=0xFFFFFFFE, out_sat=0.
REQ-019 Backpressure: send 5 consecutive beats with out_ready=0 for 6 cycles.
- in_ready drops after 3 accepted beats.
- All 5 beats emerge in order, with out_data stable while stalled.
REQ-020 Write collision: coef_we to idx 7 (0x08000 -> 0x10000) in the same cycle as a beat with idx 7 and a=4 -> out=4.
- The next beat with idx 7 and a=4 -> out=8.
REQ-021 Reset mid-stream: assert rst with 3 beats in flight.
- out_valid=0 immediately.
- No stale beat emerges after release.
